// File: rtl/conv_pkg.sv
// conv_pkg: shared sizes and FSM state type for the 2x2 convolution sequencer.
package conv_pkg;
   localparam int IMG_BYTES  = 30;
   localparam int FILT_BYTES = 12;
   localparam int OUT_WORDS  = 4;
   localparam int OUT_W      = 16;
   localparam int IMG_W      = IMG_BYTES * 8;
   localparam int FILT_W     = FILT_BYTES * 8;
   typedef enum logic [2:0] {IDLE, LOAD_FILT, LOAD_IMG, COMPUTE, DRAIN} conv_seq_state_t;
endpackage

// File: rtl/conv_out_serializer.sv
// conv_out_serializer: holds the captured core result and streams it MSB word first.
module conv_out_serializer
   import conv_pkg::*;
(
   input  logic                       clk_spi,
   input  logic                       rst_n,
   input  logic                       load,
   input  logic [OUT_WORDS*OUT_W-1:0] din,
   input  logic                       m_ready,
   output logic                       m_valid,
   output logic [OUT_W-1:0]           m_data,
   output logic                       m_last,
   output logic                       done
);
   logic [OUT_WORDS*OUT_W-1:0] hold;
   logic [1:0]                 idx;
   logic [5:0]                 pos;
   logic                       pend;
   assign pos    = 6'(OUT_WORDS*OUT_W-1) - {idx, 4'b0000};
   assign m_data = hold[pos -: OUT_W];
   assign m_last = m_valid && idx == 2'(OUT_WORDS-1);
   assign done   = m_last && m_ready;
   // valid trails the capture by one cycle so the first word is registered
   always_ff @(posedge clk_spi or negedge rst_n) begin
      if (!rst_n) begin
         hold    <= '0;
         idx     <= '0;
         pend    <= 1'b0;
         m_valid <= 1'b0;
      end else begin
         pend <= load;
         if (load) hold <= din;
         if (pend) m_valid <= 1'b1;
         else if (done) m_valid <= 1'b0;
         if (m_valid && m_ready) idx <= done ? '0 : idx + 1'b1;
      end
   end
endmodule

// File: rtl/conv_2x2_seq_ctrl.sv
// conv_2x2_seq_ctrl: assembles filter/image buses from a byte stream, waits the core
// latency, then hands the core result to the output serializer.
module conv_2x2_seq_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned CORE_LAT = 2
) (
   input  logic                       clk_spi,
   input  logic                       rst_n,
   input  logic                       s_valid,
   input  logic [7:0]                 s_data,
   output logic                       s_ready,
   input  logic                       filt_reload,
   output logic [IMG_W-1:0]           core_image,
   output logic [FILT_W-1:0]          core_filter,
   input  logic [OUT_WORDS*OUT_W-1:0] core_out,
   output logic                       m_valid,
   output logic [OUT_W-1:0]           m_data,
   output logic                       m_last,
   input  logic                       m_ready,
   output logic                       busy,
   output logic                       filt_valid
);
   conv_seq_state_t state, state_n;
   logic [5:0] byte_cnt;
   logic [3:0] lat_cnt;
   logic [6:0] filt_pos;
   logic [7:0] img_pos;
   logic       acc, last_byte, filt_wr, img_wr, load, done;
   assign acc       = s_valid && s_ready;
   assign filt_wr   = acc && (state == LOAD_FILT || (state == IDLE && filt_reload));
   assign img_wr    = acc && !filt_wr;
   assign last_byte = (state == LOAD_FILT && byte_cnt == 6'(FILT_BYTES-1)) ||
                      (state == LOAD_IMG && byte_cnt == 6'(IMG_BYTES-1));
   assign filt_pos  = 7'(FILT_W-1) - 7'({byte_cnt, 3'b000});
   assign img_pos   = 8'(IMG_W-1) - 8'({byte_cnt, 3'b000});
   always_ff @(posedge clk_spi or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      s_ready = state == IDLE || state == LOAD_FILT || state == LOAD_IMG;
      busy    = state != IDLE;
      load    = state == COMPUTE && lat_cnt == 4'(CORE_LAT);
      case (state)
         IDLE:      if (acc) state_n = filt_reload ? LOAD_FILT : LOAD_IMG;
         LOAD_FILT: if (acc && last_byte) state_n = LOAD_IMG;
         LOAD_IMG:  if (acc && last_byte) state_n = COMPUTE;
         COMPUTE:   if (load) state_n = DRAIN;
         DRAIN:     if (done) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end
   // buses change only on accepted bytes, so they stay frozen through COMPUTE and DRAIN
   always_ff @(posedge clk_spi or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt    <= '0;
         lat_cnt     <= '0;
         filt_valid  <= 1'b0;
         core_filter <= '0;
         core_image  <= '0;
      end else begin
         if (acc) byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
         lat_cnt <= (state == COMPUTE && !load) ? lat_cnt + 1'b1 : '0;
         if (filt_wr) core_filter[filt_pos -: 8] <= s_data;
         if (img_wr) core_image[img_pos -: 8] <= s_data;
         if (filt_wr && last_byte) filt_valid <= 1'b1;
      end
   end
   conv_out_serializer u_ser (
      .clk_spi (clk_spi),
      .rst_n   (rst_n),
      .load    (load),
      .din     (core_out),
      .m_ready (m_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_last  (m_last),
      .done    (done)
   );
endmodule

// File: tb/tb_conv_2x2_seq_ctrl.sv
// tb_conv_2x2_seq_ctrl: scoreboard bench run against three core latencies in parallel,
// each copy with its own behavioural core, stimulus and output monitor.
module tb_conv_2x2_seq_ctrl;
   typedef struct packed {logic [15:0] d; logic l;} exp_t;
   localparam int LATS [3] = '{2, 0, 5};
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int errs = 0;
   int chks = 0;
   logic [2:0] fin = '0;
   // byte i of a bus sits at [W-1-8i -: 8]; image is 2 rows x 5 cols x 3 ch, filter 2x2x3
   function automatic logic [63:0] conv_model(input logic [239:0] img, input logic [95:0] f);
      logic [63:0] r = '0;
      logic [15:0] a;
      for (int j = 0; j < 4; j++) begin
         a = '0;
         for (int y = 0; y < 2; y++)
            for (int x = 0; x < 2; x++)
               for (int c = 0; c < 3; c++)
                  a += 16'(8'(img >> (8 * (29 - ((y * 5 + j + x) * 3 + c))))) *
                       16'(8'(f >> (8 * (11 - ((y * 2 + x) * 3 + c)))));
         r = (r << 16) | 64'(a);
      end
      return r;
   endfunction
   for (genvar g = 0; g < 3; g++) begin : v
      localparam int L = LATS[g];
      logic rst_n, s_valid, s_ready, filt_reload, m_valid, m_last, m_ready, busy, filt_valid;
      logic [7:0] s_data;
      logic [239:0] core_image;
      logic [95:0] core_filter;
      logic [63:0] core_out;
      logic [15:0] m_data;
      logic [63:0] pipe [16];
      exp_t q [$];
      int cyc = 0;
      int acc_cyc = -1;
      logic stall = 1'b0;
      logic prev_valid = 1'b0, prev_hold = 1'b0, prev_last = 1'b0;
      logic [15:0] prev_data = '0;
      conv_2x2_seq_ctrl #(.CORE_LAT(L)) dut (
         .clk_spi(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
         .filt_reload(filt_reload), .core_image(core_image), .core_filter(core_filter),
         .core_out(core_out), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
         .m_ready(m_ready), .busy(busy), .filt_valid(filt_valid)
      );
      // core result appears L cycles after its inputs settle
      always @(posedge clk) begin
         pipe[0] <= conv_model(core_image, core_filter);
         for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
         cyc <= cyc + 1;
      end
      assign core_out = (L == 0) ? conv_model(core_image, core_filter) : pipe[(L == 0) ? 0 : L - 1];
      task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
         chks++;
         if (act !== req) begin
            errs++;
            $display("FAIL lat=%0d %s: got %0h expected %0h", L, name, act, req);
         end
      endtask
      task automatic reset_chk();
         chk("rst_s_ready", 256'(s_ready), 256'(1));
         chk("rst_m_valid", 256'(m_valid), 256'(0));
         chk("rst_m_last", 256'(m_last), 256'(0));
         chk("rst_m_data", 256'(m_data), 256'(0));
         chk("rst_busy", 256'(busy), 256'(0));
         chk("rst_filt_valid", 256'(filt_valid), 256'(0));
         chk("rst_core_image", 256'(core_image), 256'(0));
         chk("rst_core_filter", 256'(core_filter), 256'(0));
      endtask
      task automatic send(input logic [7:0] b, input logic fr);
         int n = 0;
         s_valid = 1'b1;
         s_data = b;
         filt_reload = fr;
         while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (n >= 100) begin
            chks++;
            errs++;
            $display("FAIL lat=%0d send_timeout: s_ready stayed 0, required 1", L);
         end
         @(negedge clk);
         s_valid = 1'b0;
      endtask
      // filt_reload is driven inverted on every byte after the first to show it is ignored
      task automatic frame(input logic fr, input logic [7:0] fb, input logic [7:0] ib,
                           input logic ramp, input logic [63:0] words, input logic keep);
         if (fr) for (int i = 0; i < 12; i++) send(fb, i == 0 ? 1'b1 : 1'b0);
         for (int i = 0; i < 30; i++)
            send(ramp ? 8'(i) : ib, (i == 0 && !fr) ? 1'b0 : (i == 0 ? 1'b0 : !fr));
         acc_cyc = cyc;
         for (int k = 0; k < 4; k++) q.push_back('{d: words[63-16*k -: 16], l: k == 3});
         if (keep) begin
            s_valid = 1'b1;
            s_data = 8'h00;
            filt_reload = 1'b0;
         end
      endtask
      task automatic drain();
         int n = 0;
         while ((q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
         end
         if (n >= 500) begin
            chks++;
            errs++;
            $display("FAIL lat=%0d drain_timeout: %0d words outstanding, required 0", L, q.size());
         end
      endtask
      initial begin
         m_ready = 1'b1;
         forever begin
            @(posedge clk);
            #1 m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
      always @(negedge clk) begin : mon
         exp_t e;
         if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hold = 1'b0;
         end else begin
            if (m_valid && !prev_valid && acc_cyc >= 0) begin
               chk("latency", 256'(cyc - acc_cyc), 256'(L + 2));
               acc_cyc = -1;
            end
            if (prev_hold) begin
               chk("stall_valid", 256'(m_valid), 256'(1));
               chk("stall_data", 256'(m_data), 256'(prev_data));
               chk("stall_last", 256'(m_last), 256'(prev_last));
            end
            if (m_valid) chk("s_ready_in_drain", 256'(s_ready), 256'(0));
            if (m_valid && m_ready) begin
               if (q.size() == 0) begin
                  chks++;
                  errs++;
                  $display("FAIL lat=%0d unexpected_word: got %0h, required none", L, m_data);
               end else begin
                  e = q.pop_front();
                  chk("m_data", 256'(m_data), 256'(e.d));
                  chk("m_last", 256'(m_last), 256'(e.l));
               end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            prev_valid = m_valid;
         end
      end
      initial begin
         rst_n = 1'b0;
         s_valid = 1'b0;
         s_data = '0;
         filt_reload = 1'b0;
         repeat (2) @(negedge clk);
         reset_chk();
         rst_n = 1'b1;
         @(negedge clk);
         // 12 taps x 3 x 2 = 72; filter then retained: 12 x 3 x 1 = 36
         frame(1'b1, 8'd3, 8'd2, 1'b0, {4{16'h0048}}, 1'b0);
         drain();
         chk("filt_valid_set", 256'(filt_valid), 256'(1));
         frame(1'b0, 8'd0, 8'd1, 1'b0, {4{16'h0024}}, 1'b0);
         drain();
         // unit filter over ramp image: word j = 36j + 120
         stall = 1'b1;
         frame(1'b1, 8'd1, 8'd0, 1'b1, {16'h0078, 16'h009C, 16'h00C0, 16'h00E4}, 1'b0);
         drain();
         stall = 1'b0;
         frame(1'b0, 8'd0, 8'd2, 1'b0, {4{16'h0018}}, 1'b1);
         frame(1'b0, 8'd0, 8'd0, 1'b1, {16'h0078, 16'h009C, 16'h00C0, 16'h00E4}, 1'b0);
         drain();
         for (int i = 0; i < 8; i++) send(8'd3, i == 0 ? 1'b1 : 1'b0);
         #2 rst_n = 1'b0;
         #1 reset_chk();
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         frame(1'b0, 8'd0, 8'd5, 1'b0, 64'h0, 1'b0);
         drain();
         chk("filt_valid_unloaded", 256'(filt_valid), 256'(0));
         frame(1'b1, 8'd2, 8'd1, 1'b0, {4{16'h0018}}, 1'b0);
         drain();
         chk("filt_valid_reloaded", 256'(filt_valid), 256'(1));
         fin[g] = 1'b1;
      end
   end
   initial begin
      int n = 0;
      while (fin != 3'b111 && n < 50000) begin
         @(negedge clk);
         n++;
      end
      if (fin != 3'b111) begin
         chks++;
         errs++;
         $display("FAIL global_timeout: finished=%b, required 111", fin);
      end
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end
endmodule
